forwarding_hazard_unit: RTL and testbench

- Control-side counterpart of the register bank: generates the bank's operand-mux selects `mux_sel_A`/`mux_sel_B`, `imm_sel` and the write address `RW_dm`.
- Tracks destination registers of in-flight instructions through EX, DM and WB, and detects RAW hazards against the decode-stage instruction.
- Stalls decode for one cycle on a load-use hazard.
- Counts stall cycles for performance monitoring.

---
 rtl/forwarding_hazard_unit.sv | 132 +++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : forwarding_hazard_unit
// Brief   : Tracks in-flight destinations, drives operand forwarding selects,
//           stalls decode one cycle on load-use and counts stall cycles.
// Revision: 1.0
// ============================================================================
module forwarding_hazard_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [23:0]       ins,
   output logic [1:0]        mux_sel_A,
   output logic [1:0]        mux_sel_B,
   output logic              imm_sel,
   output logic [REG_AW-1:0] RW_dm,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [1:0] SEL_BANK = 2'b00;
   localparam logic [1:0] SEL_EX   = 2'b01;
   localparam logic [1:0] SEL_DM   = 2'b10;
   localparam logic [1:0] SEL_WB   = 2'b11;

   logic              dec_imm, dec_valid, dec_load;
   logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;

   logic              ex_valid_q, dm_valid_q, wb_valid_q;
   logic [REG_AW-1:0] ex_rd_q,    dm_rd_q,    wb_rd_q;
   logic              ex_load_q;

   logic              ex_valid_d;
   logic [REG_AW-1:0] ex_rd_d;
   logic              ex_load_d;

   logic [1:0]        sel_a_d, sel_b_d, sel_a_q, sel_b_q;
   logic              imm_d, imm_q;
   logic [REG_AW-1:0] rw_dm_d, rw_dm_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic              stall_w;

   assign dec_imm   = ins[23];
   assign dec_load  = ins[21];
   assign dec_rd    = ins[18:14];
   assign dec_rs1   = ins[13:9];
   assign dec_rs2   = ins[8:4];
   // R0 is a write sink: a write to it must never be forwarded.
   assign dec_valid = ins[22] && (dec_rd != '0);

   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              exv, input logic [REG_AW-1:0] exrd,
      input logic              dmv, input logic [REG_AW-1:0] dmrd,
      input logic              wbv, input logic [REG_AW-1:0] wbrd
   );
      if (exv && exrd == src)      return SEL_EX;
      else if (dmv && dmrd == src) return SEL_DM;
      else if (wbv && wbrd == src) return SEL_WB;
      else                         return SEL_BANK;
   endfunction

   always_comb begin
      stall_w = ex_valid_q && ex_load_q &&
                ((ex_rd_q == dec_rs1) || ((ex_rd_q == dec_rs2) && !dec_imm));
      stall_w = stall_w && !rst;
   end

   always_comb begin
      ex_valid_d = dec_valid;
      ex_rd_d    = dec_rd;
      ex_load_d  = dec_load;
      sel_a_d    = fwd_sel(dec_rs1, ex_valid_q, ex_rd_q, dm_valid_q, dm_rd_q,
                           wb_valid_q, wb_rd_q);
      sel_b_d    = fwd_sel(dec_rs2, ex_valid_q, ex_rd_q, dm_valid_q, dm_rd_q,
                           wb_valid_q, wb_rd_q);
      imm_d      = dec_imm;
      cnt_d      = cnt_q;
      if (stall_w) begin
         // Bubble into EX; the held instruction re-decodes next cycle.
         ex_valid_d = 1'b0;
         ex_rd_d    = '0;
         ex_load_d  = 1'b0;
         sel_a_d    = SEL_BANK;
         sel_b_d    = SEL_BANK;
         imm_d      = 1'b0;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      rw_dm_d = ex_valid_q ? ex_rd_q : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_rd_q    <= '0;
         ex_load_q  <= 1'b0;
         dm_valid_q <= 1'b0;
         dm_rd_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         sel_a_q    <= SEL_BANK;
         sel_b_q    <= SEL_BANK;
         imm_q      <= 1'b0;
         rw_dm_q    <= '0;
         cnt_q      <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_rd_q    <= ex_rd_d;
         ex_load_q  <= ex_load_d;
         dm_valid_q <= ex_valid_q;
         dm_rd_q    <= ex_rd_q;
         wb_valid_q <= dm_valid_q;
         wb_rd_q    <= dm_rd_q;
         sel_a_q    <= sel_a_d;
         sel_b_q    <= sel_b_d;
         imm_q      <= imm_d;
         rw_dm_q    <= rw_dm_d;
         cnt_q      <= cnt_d;
      end
   end

   assign mux_sel_A   = sel_a_q;
   assign mux_sel_B   = sel_b_q;
   assign imm_sel     = imm_q;
   assign RW_dm       = rw_dm_q;
   assign stall       = stall_w;
   assign stall_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_forwarding_hazard_unit
// Brief   : Randomized self-checking bench with a history-based reference model.
// Revision: 1.0
// ============================================================================
module tb_forwarding_hazard_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] ins = '0;
   logic [1:0]  mux_sel_A, mux_sel_B;
   logic        imm_sel;
   logic [4:0]  RW_dm;
   logic        stall;
   logic [7:0]  stall_count;

   int checks = 0;
   int errors = 0;

   forwarding_hazard_unit #(.REG_AW(5), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .ins(ins),
      .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .imm_sel(imm_sel),
      .RW_dm(RW_dm), .stall(stall), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Reference: hist[d] is the instruction issued d+1 cycles before decode.
   logic       h_v[3];
   logic [4:0] h_rd[3];
   logic       h_ld[3];
   logic [1:0] e_a, e_b;
   logic       e_imm;
   logic [4:0] e_rw;
   int         e_cnt;
   logic       e_stall;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [23:0] mk(input bit imm, input bit wr, input bit ld,
                                      input int rd, input int rs1, input int rs2);
      logic [23:0] w;
      w = '0;
      w[23] = imm; w[22] = wr; w[21] = ld;
      w[18:14] = rd[4:0]; w[13:9] = rs1[4:0]; w[8:4] = rs2[4:0];
      return w;
   endfunction

   function automatic logic [1:0] nearest(input logic [4:0] s);
      for (int d = 0; d < 3; d++)
         if (h_v[d] && h_rd[d] == s) return 2'(d + 1);
      return 2'd0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         h_v[d] = 1'b0; h_rd[d] = '0; h_ld[d] = 1'b0;
      end
      e_a = '0; e_b = '0; e_imm = 1'b0; e_rw = '0; e_cnt = 0; e_stall = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".selA"}, mux_sel_A, e_a);
      chk({tag, ".selB"}, mux_sel_B, e_b);
      chk({tag, ".imm"},  imm_sel,   e_imm);
      chk({tag, ".RWdm"}, RW_dm,     e_rw);
      chk({tag, ".cnt"},  stall_count, e_cnt);
   endtask

   task automatic step(input logic [23:0] v);
      logic [1:0] na, nb;
      @(negedge clk);
      ins = v;
      #1;
      e_stall = h_v[0] && h_ld[0] &&
                (h_rd[0] == v[13:9] || (!v[23] && h_rd[0] == v[8:4]));
      na = nearest(v[13:9]);
      nb = nearest(v[8:4]);
      chk("stall", stall, e_stall);
      @(posedge clk);
      e_rw = h_v[1 - 1] ? h_rd[0] : 5'd0;
      h_v[2] = h_v[1]; h_rd[2] = h_rd[1]; h_ld[2] = h_ld[1];
      h_v[1] = h_v[0]; h_rd[1] = h_rd[0]; h_ld[1] = h_ld[0];
      if (e_stall) begin
         h_v[0] = 1'b0; h_rd[0] = '0; h_ld[0] = 1'b0;
         e_a = '0; e_b = '0; e_imm = 1'b0;
         if (e_cnt < 255) e_cnt++;
      end else begin
         h_v[0] = v[22] && (v[18:14] != 0); h_rd[0] = v[18:14]; h_ld[0] = v[21];
         e_a = na; e_b = nb; e_imm = v[23];
      end
      #1;
      check_regs("step");
   endtask

   initial begin
      logic [23:0] cur;
      model_reset();
      #2;
      chk("rst.stall", stall, 0);
      check_regs("rst");
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back ALU and distance sweep
      step(mk(0, 1, 0, 5, 0, 0));
      step(mk(0, 0, 0, 0, 5, 7));
      chk("b2b.selA", mux_sel_A, 1);
      for (int gap = 0; gap < 4; gap++) begin
         step(mk(0, 1, 0, 3, 0, 0));
         for (int k = 0; k < gap; k++) step(mk(0, 1, 0, 12, 1, 2));
         step(mk(0, 0, 0, 0, 3, 1));
         chk("dist.selA", mux_sel_A, (gap < 3) ? gap + 1 : 0);
      end

      // Load-use, imm form, R0/non-writer, priority
      step(mk(0, 1, 1, 9, 0, 0));
      step(mk(0, 0, 0, 0, 1, 9));
      step(mk(0, 0, 0, 0, 1, 9));
      chk("lu.selB", mux_sel_B, 2);
      step(mk(0, 1, 1, 9, 0, 0));
      step(mk(1, 0, 0, 0, 1, 9));
      step(mk(0, 1, 0, 0, 0, 0));
      step(mk(0, 0, 0, 4, 0, 0));
      step(mk(0, 0, 0, 0, 4, 0));
      step(mk(0, 1, 0, 6, 0, 0));
      step(mk(0, 1, 0, 6, 0, 0));
      step(mk(0, 0, 0, 0, 6, 6));
      chk("prio.selB", mux_sel_B, 1);

      // Random traffic; ins is held while stall is high
      cur = '0;
      for (int i = 0; i < 600; i++) begin
         if (!e_stall) begin
            cur = 24'($urandom);
            cur[18:14] = 5'($urandom_range(0, 7));
            cur[13:9]  = 5'($urandom_range(0, 7));
            cur[8:4]   = 5'($urandom_range(0, 7));
         end
         step(cur);
      end

      // Saturation: a self-dependent load stalls every other cycle
      for (int i = 0; i < 620; i++) step(mk(0, 1, 1, 9, 9, 0));
      chk("sat.cnt", stall_count, 255);

      // Reset while stalled
      step(mk(0, 1, 1, 9, 0, 0));
      @(negedge clk);
      ins = mk(0, 0, 0, 0, 1, 9);
      #1;
      chk("mid.stall_pre", stall, 1);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid.stall", stall, 0);
      check_regs("mid");
      @(negedge clk);
      rst = 1'b0;
      step(mk(0, 0, 0, 0, 9, 9));
      chk("post.selA", mux_sel_A, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
